c1541_sd_arbiter: RTL
=====================

C1541_SD_ARBITER -- requirements
Module: c1541_sd_arbiter

Interface
REQ-001 Parameter NDRIVES, default 4: number of c1541_sd drive instances sharing one SD block interface (1..4).
REQ-002 Parameter ACK_TIMEOUT, default 24'd16000000: clk_sys cycles allowed between request issue and sd_ack rise.
REQ-003 Clock and reset: one clock, clk_sys; reset is asynchronous and active-low, reset_n.
REQ-004 clk_sys  in  1  system clock; all logic on its rising edge.
REQ-005 reset_n  in  1  asynchronous active-low reset.
REQ-006 drv_lba  in  NDRIVES*32  per-drive sd_lba, drive i at bits [32i+31:32i].
REQ-007 drv_rd  in  NDRIVES  per-drive read request level.
REQ-008 drv_wr  in  NDRIVES  per-drive write request level.
REQ-009 drv_buff_din  in  NDRIVES*8  per-drive write data toward the host.
REQ-010 drv_ack  out  NDRIVES  per-drive sd_ack.
REQ-011 drv_buff_wr  out  NDRIVES  per-drive sd_buff_wr.
REQ-012 sd_lba  out  32 / sd_rd  out  1 / sd_wr  out  1: host-side request.
REQ-013 sd_ack  in  1 / sd_buff_wr  in  1 / sd_buff_din  out  8: host-side handshake and data.
REQ-014 grant  out  2  index of owning drive; busy  out  1  owner active; timeout_err  out  1  one-cycle pulse.
REQ-015 sd_buff_addr and sd_buff_dout are broadcast to all drives outside this block.

Function
REQ-016 State machine: IDLE, REQ, XFER, DONE.
REQ-017 IDLE: pending set = drv_rd|drv_wr; empty -> stay IDLE.
REQ-018 Non-empty pending set: round-robin selection, first pending index at or after ptr, modulo NDRIVES.
REQ-019 On selection: grant <= winner; sd_lba <= its drv_lba; next state REQ.
REQ-020 Latency: request sampled in IDLE at cycle N -> sd_lba valid and sd_rd/sd_wr high at N+1.
REQ-021 REQ: sd_rd <= drv_rd[grant], sd_wr <= drv_wr[grant], registered each cycle.
REQ-022 Same drive asserting rd and wr together: rd forwarded, wr masked until next grant.
REQ-023 REQ, sd_ack=1 -> XFER.
REQ-024 REQ, owner drops both requests before sd_ack -> IDLE; ptr unchanged; no error.
REQ-025 REQ, sd_ack absent for ACK_TIMEOUT consecutive cycles -> DONE; timeout_err pulses one cycle.
REQ-026 XFER: sd_rd/sd_wr continue to track the owner; sd_ack=0 -> DONE.
REQ-027 DONE (one cycle): sd_rd=sd_wr=0; ptr <= (grant+1) mod NDRIVES; next IDLE.
REQ-028 drv_ack[i] = sd_ack & (i==grant) & state in {REQ,XFER}; combinational, zero latency.
REQ-029 drv_buff_wr[i]: same gating applied to sd_buff_wr.
REQ-030 sd_buff_din = drv_buff_din[grant] when state in {REQ,XFER}, else 8'h00.
REQ-031 sd_ack or sd_buff_wr while IDLE/DONE: ignored, never forwarded.
REQ-032 Non-owners may assert/drop requests at any time; only pending selection is affected.
REQ-033 busy = state != IDLE.

Reset
REQ-034 reset_n low, at any time including mid-XFER, forces immediately:
  - state=IDLE, ptr=0, grant=0
  - sd_lba=0, sd_rd=0, sd_wr=0
  - timeout counter=0, timeout_err=0
REQ-035 All drv_ack and drv_buff_wr low while reset_n is low.

Structure
REQ-036 Shared package c1541_pkg: state enum, MAX_DRIVES=4, ACK_TIMEOUT default.
REQ-037 One sub-module, c1541_rr_pick: combinational round-robin index from pending vector and ptr.

Verification
REQ-038 Drive 1 drv_rd=1, lba=32'h0000_0165:
  - next cycle: sd_rd=1, sd_lba=32'h165, grant=1
  - sd_ack 512 cycles: drv_ack=4'b0010 only, 512 sd_buff_wr forwarded to drive 1 only
  - after ack falls: DONE, then IDLE, ptr=2
REQ-039 Drives 0 and 2 request together with ptr=0:
  - drive 0 served first, then drive 2
  - drive 0 re-requests during drive 2 XFER -> drive 0 served after DONE
REQ-040 Drive 3 drv_wr=1, drv_buff_din=8'hA5 -> sd_buff_din=8'hA5 during XFER, 8'h00 afterwards.
REQ-041 Grant issued, no sd_ack, ACK_TIMEOUT=100:
  - timeout_err pulses at cycle 100 of REQ
  - sd_rd low in DONE; arbitration resumes at ptr+1
REQ-042 reset_n low mid-XFER:
  - all outputs zero asynchronously
  - following sd_ack/sd_buff_wr not forwarded to any drive
REQ-043 sd_ack pulse while IDLE -> drv_ack=0, state stays IDLE.

Source files
------------

// File: rtl/c1541_sd_arbiter_pkg.sv
// Shared types for the c1541 SD arbiter: FSM state encoding,
// drive index type, drive-count limit and default ack timeout.
package c1541_pkg;

    localparam int MAX_DRIVES = 4;
    localparam logic [23:0] ACK_TIMEOUT_DEF = 24'd16000000;

    typedef logic [1:0] drv_idx_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_XFER = 2'd2,
        ST_DONE = 2'd3
    } arb_state_e;

    // Next drive index after v, wrapping at n drives.
    function automatic drv_idx_t wrap_inc(input drv_idx_t v, input int n);
        if (int'(v) + 1 >= n) begin
            return '0;
        end
        return v + drv_idx_t'(1);
    endfunction

endpackage

// File: rtl/c1541_sd_arbiter_if.sv
// Bundle of per-drive request/ack lines and the shared host SD port.
// master: the arbiter; slave: drives plus host around it.
interface c1541_sd_arbiter_if #(
    parameter int NDRIVES = 4
);
    // drive side
    logic [NDRIVES*32-1:0] drv_lba;
    logic [NDRIVES-1:0]    drv_rd;
    logic [NDRIVES-1:0]    drv_wr;
    logic [NDRIVES*8-1:0]  drv_buff_din;
    logic [NDRIVES-1:0]    drv_ack;
    logic [NDRIVES-1:0]    drv_buff_wr;
    // host side
    logic [31:0]           sd_lba;
    logic                  sd_rd;
    logic                  sd_wr;
    logic                  sd_ack;
    logic                  sd_buff_wr;
    logic [7:0]            sd_buff_din;

    modport master (
        input  drv_lba,
        input  drv_rd,
        input  drv_wr,
        input  drv_buff_din,
        input  sd_ack,
        input  sd_buff_wr,
        output drv_ack,
        output drv_buff_wr,
        output sd_lba,
        output sd_rd,
        output sd_wr,
        output sd_buff_din
    );

    modport slave (
        output drv_lba,
        output drv_rd,
        output drv_wr,
        output drv_buff_din,
        output sd_ack,
        output sd_buff_wr,
        input  drv_ack,
        input  drv_buff_wr,
        input  sd_lba,
        input  sd_rd,
        input  sd_wr,
        input  sd_buff_din
    );

endinterface

// File: rtl/c1541_sd_arbiter_rr_pick.sv
// Combinational round-robin picker: first pending drive at or after ptr_i.
// Ports: pend_i request vector, ptr_i start index, valid_o/idx_o winner.
module c1541_rr_pick
    import c1541_pkg::*;
#(
    parameter int NDRIVES = 4
) (
    input  logic [NDRIVES-1:0] pend_i,
    input  drv_idx_t           ptr_i,
    output logic               valid_o,
    output drv_idx_t           idx_o
);

    function automatic drv_idx_t slot(input drv_idx_t p, input int k);
        return drv_idx_t'((int'(p) + k) % NDRIVES);
    endfunction

    // Scan from the far end so the nearest pending slot is written last.
    always_comb begin
        valid_o = 1'b0;
        idx_o   = '0;
        for (int k = NDRIVES - 1; k >= 0; k--) begin
            if (pend_i[slot(ptr_i, k)]) begin
                valid_o = 1'b1;
                idx_o   = slot(ptr_i, k);
            end
        end
    end

endmodule

// File: rtl/c1541_sd_arbiter.sv
// Shares one SD block port among NDRIVES c1541 drives (round-robin).
// Ports: clk_sys/reset_n, bus (drive + host lines), grant, busy, timeout_err.
module c1541_sd_arbiter
    import c1541_pkg::*;
#(
    parameter int          NDRIVES     = 4,
    parameter logic [23:0] ACK_TIMEOUT = ACK_TIMEOUT_DEF
) (
    input  logic               clk_sys,
    input  logic               reset_n,
    c1541_sd_arbiter_if.master bus,
    output drv_idx_t           grant,
    output logic               busy,
    output logic               timeout_err
);

    arb_state_e  state_q, state_d;
    drv_idx_t    ptr_q, ptr_d;
    drv_idx_t    grant_q, grant_d;
    logic [31:0] lba_q, lba_d;
    logic        rd_q, rd_d;
    logic        wr_q, wr_d;
    logic        wmask_q, wmask_d;
    logic [23:0] cnt_q, cnt_d;
    logic        tmo;

    logic [NDRIVES-1:0] pend;
    logic               pick_vld;
    drv_idx_t           pick_idx;
    logic               active;

    assign pend = bus.drv_rd | bus.drv_wr;

    c1541_rr_pick #(
        .NDRIVES (NDRIVES)
    ) u_pick (
        .pend_i  (pend),
        .ptr_i   (ptr_q),
        .valid_o (pick_vld),
        .idx_o   (pick_idx)
    );

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            grant_q <= '0;
            lba_q   <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            wmask_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            lba_q   <= lba_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            wmask_q <= wmask_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        grant_d = grant_q;
        lba_d   = lba_q;
        wmask_d = wmask_q;
        cnt_d   = '0;
        tmo     = 1'b0;
        rd_d    = 1'b0;
        wr_d    = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (pick_vld) begin
                    grant_d = pick_idx;
                    lba_d   = bus.drv_lba[{pick_idx, 5'd0} +: 32];
                    // read wins a simultaneous rd+wr; wr stays
                    // masked for the rest of this grant
                    wmask_d = bus.drv_rd[pick_idx]
                            & bus.drv_wr[pick_idx];
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                if (bus.sd_ack) begin
                    state_d = ST_XFER;
                end else if (!pend[grant_q]) begin
                    // owner withdrew: no error, ptr untouched
                    state_d = ST_IDLE;
                end else if (cnt_q == ACK_TIMEOUT - 24'd1) begin
                    state_d = ST_DONE;
                    tmo     = 1'b1;
                end else begin
                    cnt_d = cnt_q + 24'd1;
                end
            end
            ST_XFER: begin
                if (!bus.sd_ack) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                ptr_d   = wrap_inc(grant_q, NDRIVES);
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Host request lines follow the owner only while it is
        // (or is about to be) in REQ/XFER; low everywhere else.
        if (state_d == ST_REQ || state_d == ST_XFER) begin
            rd_d = bus.drv_rd[grant_d];
            wr_d = bus.drv_wr[grant_d] & ~wmask_d;
        end
    end

    assign active = (state_q == ST_REQ) || (state_q == ST_XFER);

    logic [NDRIVES-1:0] ack_v;
    logic [NDRIVES-1:0] bwr_v;

    always_comb begin
        ack_v = '0;
        bwr_v = '0;
        if (active) begin
            ack_v[grant_q] = bus.sd_ack;
            bwr_v[grant_q] = bus.sd_buff_wr;
        end
    end

    assign bus.drv_ack     = ack_v;
    assign bus.drv_buff_wr = bwr_v;
    assign bus.sd_lba      = lba_q;
    assign bus.sd_rd       = rd_q;
    assign bus.sd_wr       = wr_q;
    assign bus.sd_buff_din = active
                           ? bus.drv_buff_din[{grant_q, 3'd0} +: 8]
                           : 8'h00;

    assign grant       = grant_q;
    assign busy        = (state_q != ST_IDLE);
    assign timeout_err = tmo;

endmodule
